// File: rtl/seq_accumulator.sv
// -----------------------------------------------------------------------------
// seq_accumulator
// Streaming accumulator. A start_i pulse opens a new sequence; unsigned words
// arriving over a valid/ready handshake are summed until a zero terminator is
// accepted, at which point done_o pulses for one cycle with the final sum_o and
// count_o. Sum carry-out and term-count overflow set the sticky err_o and the
// remainder of the stream (up to and including its terminator) is drained.
//
// Optional feature macro: SEQ_ACC_SAT_EN
//   defined   : a sum carry saturates sum_o to all-ones and sets sticky sat_o
//               instead of erroring; count overflow still errors.
//   undefined : a sum carry errors; sat_o is constant 0.
//
// Ports
//   clk         in   clock, rising edge
//   rstn        in   asynchronous active-low reset
//   start_i     in   open a new sequence (clears sum, count, err, sat)
//   in_valid_i  in   in_data_i is valid
//   in_ready_o  out  word accepted this cycle if in_valid_i is high
//   in_data_i   in   WIDTH-bit unsigned term, zero is the terminator
//   done_o      out  one-cycle pulse after the terminator is accepted
//   err_o       out  sticky overflow flag
//   sat_o       out  sticky saturation flag
//   sum_o       out  accumulated sum
//   count_o     out  number of nonzero terms added
// -----------------------------------------------------------------------------
module seq_accumulator #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             done_o,
  output logic             err_o,
  output logic             sat_o,
  output logic [WIDTH-1:0] sum_o,
  output logic [CNT_W-1:0] count_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [WIDTH-1:0] SUM_MAX = {WIDTH{1'b1}};

  // Zero-extended add; the top bit is the carry-out.
  function automatic logic [WIDTH:0] wide_add(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    wide_add = {1'b0, a} + {1'b0, b};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q,   err_d;
  logic             sat_q,   sat_d;
  logic             done_q,  done_d;
  logic             accept_s;
  logic [WIDTH:0]   add_s;

  // Ready is combinational so that start_i blocks acceptance in its own cycle.
  assign in_ready_o = ((state_q == ST_ACC) || (state_q == ST_DRAIN)) && !start_i;
  assign accept_s   = in_valid_i && in_ready_o;
  assign add_s      = wide_add(sum_q, in_data_i);

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    count_d = count_q;
    err_d   = err_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    if (start_i) begin
      state_d = ST_ACC;
      sum_d   = {WIDTH{1'b0}};
      count_d = {CNT_W{1'b0}};
      err_d   = 1'b0;
      sat_d   = 1'b0;
    end else if (accept_s) begin
      case (state_q)
        ST_ACC: begin
          if (in_data_i == {WIDTH{1'b0}}) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (count_q == CNT_MAX) begin
            // Count overflow takes precedence over a simultaneous carry.
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else if (add_s[WIDTH]) begin
`ifdef SEQ_ACC_SAT_EN
            sum_d   = SUM_MAX;
            sat_d   = 1'b1;
            count_d = count_q + CNT_W'(1);
`else
            err_d   = 1'b1;
            state_d = ST_DRAIN;
`endif
          end else begin
            sum_d   = add_s[WIDTH-1:0];
            count_d = count_q + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (in_data_i == {WIDTH{1'b0}}) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
`ifndef SEQ_ACC_SAT_EN
    sat_d = 1'b0;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      sum_q   <= {WIDTH{1'b0}};
      count_q <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign sum_o   = sum_q;
  assign count_o = count_q;
  assign err_o   = err_q;
  assign sat_o   = sat_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_seq_accumulator.sv
module tb_seq_accumulator;

`ifdef SEQ_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, valid;
  logic [15:0] data;
  logic        ready, done, err, sat;
  logic [15:0] sum;
  logic [7:0]  cnt;

  logic        start4, valid4;
  logic [15:0] data4;
  logic        ready4, done4, err4, sat4;
  logic [15:0] sum4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  seq_accumulator #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .start_i(start), .in_valid_i(valid),
    .in_ready_o(ready), .in_data_i(data), .done_o(done), .err_o(err),
    .sat_o(sat), .sum_o(sum), .count_o(cnt));

  seq_accumulator #(.WIDTH(16), .CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .start_i(start4), .in_valid_i(valid4),
    .in_ready_o(ready4), .in_data_i(data4), .done_o(done4), .err_o(err4),
    .sat_o(sat4), .sum_o(sum4), .count_o(cnt4));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (integer arithmetic) ----------------
  longint m_sum;
  int     m_cnt;
  bit     m_err, m_sat, m_done;
  bit     m_open;      // a sequence is open and words are being taken
  bit     m_discard;   // overflow happened, words until terminator ignored
  bit     m_rdy;       // model ready for the cycle just applied
  logic   rdy_seen;

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_err = 0; m_sat = 0; m_done = 0;
    m_open = 0; m_discard = 0;
  endtask

  task automatic model_edge(input bit st, input bit v, input logic [15:0] d);
    m_done = 0;
    if (st) begin
      m_sum = 0; m_cnt = 0; m_err = 0; m_sat = 0;
      m_open = 1; m_discard = 0;
    end else if (v && m_open) begin
      if (d == 16'h0) begin
        m_done = 1;
        m_open = 0;
      end else if (!m_discard) begin
        if (m_cnt == 255) begin
          m_err = 1; m_discard = 1;
        end else if (m_sum + longint'(d) > 65535) begin
          if (SAT) begin
            m_sum = 65535; m_sat = 1; m_cnt = m_cnt + 1;
          end else begin
            m_err = 1; m_discard = 1;
          end
        end else begin
          m_sum = m_sum + longint'(d);
          m_cnt = m_cnt + 1;
        end
      end
    end
  endtask

  // Drive one cycle on the main DUT, capture ready before the edge, update model.
  task automatic step(input bit st, input bit v, input logic [15:0] d);
    @(negedge clk);
    start = st; valid = v; data = d;
    #1;
    rdy_seen = ready;
    m_rdy = m_open && !st;
    @(posedge clk);
    model_edge(st, v, d);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".ready"}, {31'd0, rdy_seen}, {31'd0, m_rdy});
    check({tag, ".sum"},   {16'd0, sum}, m_sum[31:0]);
    check({tag, ".count"}, {24'd0, cnt}, m_cnt);
    check({tag, ".err"},   {31'd0, err}, {31'd0, m_err});
    check({tag, ".sat"},   {31'd0, sat}, {31'd0, m_sat});
    check({tag, ".done"},  {31'd0, done}, {31'd0, m_done});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          st;
    bit          v;
    logic [15:0] d;
    bit          e_rdy;
    logic [15:0] e_sum;
    logic [7:0]  e_cnt;
    bit          e_err;
    bit          e_sat;
    bit          e_done;
  } vec_t;

  vec_t tbl[$];

  initial begin : main
    logic [15:0] ov_sum;
    logic [7:0]  ov_c2, ov_c3;
    ov_sum = SAT ? 16'hFFFF : 16'hFFF0;
    ov_c2  = SAT ? 8'd2 : 8'd1;
    ov_c3  = SAT ? 8'd3 : 8'd1;

    // basic: 3,5,7,0
    tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 16'd0,  8'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0003, 1'b1, 16'd3,  8'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0005, 1'b1, 16'd8,  8'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0007, 1'b1, 16'd15, 8'd3, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0000, 1'b1, 16'd15, 8'd3, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 16'h0009, 1'b0, 16'd15, 8'd3, 1'b0, 1'b0, 1'b0});
    // empty sequence
    tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 16'd0,  8'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0000, 1'b1, 16'd0,  8'd0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 16'd0,  8'd0, 1'b0, 1'b0, 1'b0});
    // sum overflow
    tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 16'd0,    8'd0,  1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'hFFF0, 1'b1, 16'hFFF0, 8'd1,  1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0020, 1'b1, ov_sum,   ov_c2, !SAT, SAT,  1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0001, 1'b1, ov_sum,   ov_c3, !SAT, SAT,  1'b0});
    tbl.push_back('{1'b0, 1'b1, 16'h0000, 1'b1, ov_sum,   ov_c3, !SAT, SAT,  1'b1});
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, ov_sum,   ov_c3, !SAT, SAT,  1'b0});

    rstn = 1'b0; start = 1'b0; valid = 1'b0; data = 16'h0;
    start4 = 1'b0; valid4 = 1'b0; data4 = 16'h0;
    model_reset();
    #3;
    check("rst.sum",   {16'd0, sum}, 32'd0);
    check("rst.count", {24'd0, cnt}, 32'd0);
    check("rst.err",   {31'd0, err}, 32'd0);
    check("rst.sat",   {31'd0, sat}, 32'd0);
    check("rst.done",  {31'd0, done}, 32'd0);
    check("rst.ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // table-driven directed vectors
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].st, tbl[i].v, tbl[i].d);
      check($sformatf("tbl%0d.ready", i), {31'd0, rdy_seen}, {31'd0, tbl[i].e_rdy});
      check($sformatf("tbl%0d.sum", i),   {16'd0, sum},  {16'd0, tbl[i].e_sum});
      check($sformatf("tbl%0d.count", i), {24'd0, cnt},  {24'd0, tbl[i].e_cnt});
      check($sformatf("tbl%0d.err", i),   {31'd0, err},  {31'd0, tbl[i].e_err});
      check($sformatf("tbl%0d.sat", i),   {31'd0, sat},  {31'd0, tbl[i].e_sat});
      check($sformatf("tbl%0d.done", i),  {31'd0, done}, {31'd0, tbl[i].e_done});
    end

    // handshake / restart: start with a terminator is not accepted
    step(1'b1, 1'b0, 16'd0);
    step(1'b0, 1'b1, 16'd10);  check_model("hs.w10");
    step(1'b0, 1'b0, 16'd0);   check_model("hs.gap1");
    step(1'b0, 1'b0, 16'd77);  check_model("hs.gap2");
    check("hs.sum10", {16'd0, sum}, 32'd10);
    step(1'b1, 1'b1, 16'd0);   check_model("hs.restart");
    check("hs.ready_blocked", {31'd0, rdy_seen}, 32'd0);
    check("hs.no_done", {31'd0, done}, 32'd0);
    step(1'b1, 1'b1, 16'd5);   check_model("hs.start_hold");
    step(1'b0, 1'b1, 16'd4);   check_model("hs.w4");
    step(1'b0, 1'b1, 16'd0);   check_model("hs.term");
    check("hs.final_sum", {16'd0, sum}, 32'd4);
    check("hs.final_cnt", {24'd0, cnt}, 32'd1);
    check("hs.final_done", {31'd0, done}, 32'd1);

    // reset mid-sequence
    step(1'b1, 1'b0, 16'd0);
    step(1'b0, 1'b1, 16'd9);
    step(1'b0, 1'b1, 16'd9);   check_model("mr.pre");
    @(negedge clk);
    valid = 1'b1; data = 16'd9; rstn = 1'b0;
    #1;
    check("mr.sum",   {16'd0, sum}, 32'd0);
    check("mr.count", {24'd0, cnt}, 32'd0);
    check("mr.err",   {31'd0, err}, 32'd0);
    check("mr.done",  {31'd0, done}, 32'd0);
    check("mr.ready", {31'd0, ready}, 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, 1'b1, 16'd9);   check_model("mr.post1");
    step(1'b0, 1'b1, 16'd0);   check_model("mr.post2");

    // count overflow on the CNT_W=4 instance
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); valid4 = 1'b1; data4 = 16'd1;
      @(posedge clk); #1;
      check($sformatf("c4.sum%0d", i), {16'd0, sum4}, (i > 15) ? 32'd15 : i);
      check($sformatf("c4.cnt%0d", i), {28'd0, cnt4}, (i > 15) ? 32'd15 : i);
      check($sformatf("c4.err%0d", i), {31'd0, err4}, (i == 16) ? 32'd1 : 32'd0);
    end
    @(negedge clk); valid4 = 1'b1; data4 = 16'd0;
    @(posedge clk); #1;
    check("c4.done", {31'd0, done4}, 32'd1);
    check("c4.err_held", {31'd0, err4}, 32'd1);
    @(negedge clk); valid4 = 1'b0;
    @(posedge clk); #1;
    check("c4.done_pulse", {31'd0, done4}, 32'd0);
    check("c4.ready_idle", {31'd0, ready4}, 32'd0);

    // randomized stimulus against the model
    step(1'b1, 1'b0, 16'd0);   check_model("rnd.start");
    for (int i = 0; i < 600; i++) begin
      bit st, v;
      logic [15:0] d;
      int r;
      st = ($urandom_range(0, 24) == 0);
      v  = ($urandom_range(0, 9) < 7);
      r  = $urandom_range(0, 7);
      if (r < 2)      d = 16'd0;
      else if (r < 4) d = 16'($urandom_range(16'h8000, 16'hFFFF));
      else            d = 16'($urandom_range(1, 255));
      step(st, v, d);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_accumulator.md
# seq_accumulator

Parametrised streaming accumulator: after a `start` pulse it sums a stream of unsigned words delivered over a valid/ready handshake until a zero terminator arrives, then pulses `done` with the final sum and term count. Carry-out and term-count overflow are detected and reported through a sticky `err`, and the rest of the stream is drained. It is the generalised, handshaked successor of the fixed 16-bit sum-until-zero block in the hardware-threads chapter.

## Interface
- `WIDTH`, 16, data and sum width in bits (≥2)
- `CNT_W`, 8, term-counter width in bits (≥1); maximum accepted terms = 2^CNT_W − 1
- `clk`  in  1  clock, rising edge
- `rstn`  in  1  reset: asynchronous, active-low
- `start`  in  1  begin a new sequence; clears sum, count, err, sat
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block accepts `in_data` this cycle
- `in_data`  in  WIDTH  unsigned term; value 0 is the terminator
- `done`  out  1  one-cycle pulse: sequence terminated
- `err`  out  1  sticky overflow flag, cleared only by `start` or reset
- `sat`  out  1  sticky saturation flag (see Configuration)
- `sum`  out  WIDTH  registered accumulated sum
- `count`  out  CNT_W  registered number of nonzero terms added

## Operation
- States: IDLE, ACC, DRAIN. All outputs are registered except `in_ready`, which is `(state==ACC || state==DRAIN) && !start`.
- Word accepted = `in_valid && in_ready` at a rising edge.
- `start` in any state: sum←0, count←0, err←0, sat←0, state←ACC. No word is accepted in that cycle. `start` has priority over any word.
- IDLE: `in_ready`=0. `sum`, `count`, `err` and `sat` hold the last result.
- ACC, accepted nonzero word, WIDTH+1-bit add `{1'b0,sum}+in_data`:
  - No carry and count < max: sum←low WIDTH bits, count←count+1.
  - Carry (sum overflow): sum holds its old value, count holds, err←1, state←DRAIN. Saturating behaviour is described under Configuration.
  - count == 2^CNT_W−1 (count overflow, checked before carry): sum and count hold, err←1, state←DRAIN.
- ACC, accepted zero: done←1 for the next cycle, state←IDLE, sum and count unchanged.
- DRAIN: accepted nonzero words are discarded. An accepted zero pulses done and goes to IDLE with err held at 1.
- Reset: state IDLE, sum 0, count 0, done 0, err 0, sat 0, in_ready 0.

## Timing
- Throughput: one word per cycle while `in_valid` is high in ACC or DRAIN.
- Latency: `sum`/`count` update on the edge that accepts the word. `err` rises on the edge that accepts the overflowing word. `done` is high for exactly the one cycle after the terminator edge.
- `in_valid` low cycles (bubbles) have no effect on sum, count or state.
- `start` asserted together with a terminator in ACC: the terminator is not accepted, no `done` pulse, and the new sequence begins.
- `start` asserted for several cycles: the block stays cleared in ACC with `in_ready`=0 until `start` deasserts.
- `rstn` assertion mid-sequence: all outputs go to their reset values immediately. `in_ready` is 0 until the next `start`.

## Configuration
- Macro `SEQ_ACC_SAT_EN`.
- Defined: a sum carry in ACC does not error. Instead sum←all-ones, sat←1, count←count+1, and the state stays ACC. Later adds keep the sum at all-ones. Count overflow still sets err and enters DRAIN.
- Undefined: carry behaves as in Operation, and `sat` is tied to 0.

## Test plan
Defaults WIDTH=16, CNT_W=8 unless stated.
- Basic: start, then 3, 5, 7, 0 back-to-back → `done` pulse 1 cycle after 0; sum=15, count=3, err=0; IDLE, in_ready=0.
- Empty sequence: start, 0 → done pulse; sum=0, count=0, err=0.
- Sum overflow, no macro: start, 0xFFF0, 0x0020, 0x0001, 0 → err=1 after 2nd word; sum=0xFFF0, count=1; 0x0001 discarded; done pulse after 0, err stays 1.
  - Same stimulus with SEQ_ACC_SAT_EN: sum=0xFFFF, sat=1, err=0, count=3, done after 0.
- Count overflow, CNT_W=4: start, sixteen words of 1, then 0 → err after 16th word; sum=15, count=15; done after 0.
- Handshake/restart: start, 10 with in_valid gaps, then start together with in_valid=1/in_data=0 → no done, in_ready=0 that cycle; then 4, 0 → sum=4, count=1.
- Reset mid-sequence: start, 9, 9, then rstn low for 1 cycle → sum=0, count=0, err=0, done=0, in_ready=0 immediately and until next start.
